led_sequence_player: RTL and testbench



---
 rtl/led_sequence_player.sv | 207 ++++++++++++++++++++
 tb/tb_led_sequence_player.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequence_player.sv
// led_sequence_player: memory-mapped LED sequence buffer and autonomous player.
// The processor appends colour codes at address 7, issues start/clear commands at
// address 8 and polls the status word at address 8. While idle the LEDs echo the
// synchronized pushbuttons; during playback each colour is lit for ON_CYCLES and
// followed by GAP_CYCLES of darkness.
module led_sequence_player #(
    parameter int DEPTH      = 32,
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 12500000,
    parameter int CNT_W      = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        green_button,
    input  logic        yellow_button,
    output logic        red_led,
    output logic        blue_led,
    output logic        green_led,
    output logic        yellow_led
);

    localparam int                AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [11:0]       ADDR_APPEND = 12'd7;
    localparam logic [11:0]       ADDR_CTRL   = 12'd8;
    localparam logic [CNT_W-1:0]  ON_LAST     = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [7:0]        DEPTH_W     = 8'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_timer;
    logic [7:0]       r_count;
    logic [7:0]       r_index;
    logic             r_done;
    logic [1:0]       r_buf [DEPTH];
    logic [3:0]       r_btn_meta;
    logic [3:0]       r_btn_sync;
    logic [3:0]       r_led;
    logic [3:0]       w_led_next;

    logic             w_wr_append;
    logic             w_wr_ctrl;
    logic             w_clear;
    logic             w_start;
    logic             w_append;
    logic             w_full;
    logic             w_busy;
    logic             w_on_end;
    logic             w_gap_end;
    logic             w_last;
    logic [1:0]       w_colour;
    logic [31:0]      w_status;
    logic             w_unused_data;

    // LED bit order matches the colour code: 0 red, 1 blue, 2 green, 3 yellow.
    assign red_led    = r_led[0];
    assign blue_led   = r_led[1];
    assign green_led  = r_led[2];
    assign yellow_led = r_led[3];

    // Bus decode; clear has priority over start in the same command write.
    assign w_wr_append = wren && (addr == ADDR_APPEND);
    assign w_wr_ctrl   = wren && (addr == ADDR_CTRL);
    assign w_clear     = w_wr_ctrl && data_in[1];
    assign w_full      = (r_count == DEPTH_W);
    assign w_busy      = (r_state != S_IDLE);
    assign w_start     = w_wr_ctrl && data_in[0] && !data_in[1] &&
                         !w_busy && (r_count != 8'd0);
    assign w_append    = w_wr_append && !w_busy && !w_full;

    assign w_on_end  = (r_state == S_ON)  && (r_timer == ON_LAST);
    assign w_gap_end = (r_state == S_GAP) && (r_timer == GAP_LAST);
    assign w_last    = (r_index == r_count - 8'd1);
    assign w_colour  = r_buf[r_index[AW-1:0]];

    assign w_status = {8'd0, r_index, r_count, 5'd0, r_done, w_full, w_busy};
    assign data_out = (addr == ADDR_CTRL) ? w_status : 32'd0;

    // Only the colour bits of the store data carry information.
    assign w_unused_data = ^data_in[31:2];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples the pre-edge values regardless of block order.
            r_state <= w_state_next;
        end
    end

    // Next-state logic: clear aborts from any state, otherwise ON/GAP alternate
    // until the last entry's gap expires.
    always_comb begin
        // NOTE: default first, so every path assigns w_state_next and no latch forms.
        w_state_next = r_state;
        if (w_clear) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (w_start)   w_state_next = S_ON;
                S_ON:    if (w_on_end)  w_state_next = S_GAP;
                S_GAP:   if (w_gap_end) w_state_next = w_last ? S_IDLE : S_ON;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Phase timer: counts 0..N-1 inside ON and GAP, held at zero otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_clear || w_start || w_on_end || w_gap_end || !w_busy) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + CNT_W'(1);
        end
    end

    // Play index: restarts on start, advances after each non-final gap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_index <= 8'd0;
        end else if (w_clear || w_start) begin
            r_index <= 8'd0;
        end else if (w_gap_end && !w_last) begin
            r_index <= r_index + 8'd1;
        end
    end

    // Entry count: grows on accepted appends, emptied only by clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (w_clear) begin
            r_count <= 8'd0;
        end else if (w_append) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Sticky done flag: set when the final gap ends, cleared by start or clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_clear || w_start) begin
            r_done <= 1'b0;
        end else if (w_gap_end && w_last) begin
            r_done <= 1'b1;
        end
    end

    // Sequence storage.
    // NOTE: the buffer has no reset; r_count alone defines which entries are valid.
    always_ff @(posedge clock) begin
        if (w_append) begin
            r_buf[r_count[AW-1:0]] <= data_in[1:0];
        end
    end

    // Two-flop synchronizer for the asynchronous pushbuttons.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_btn_meta <= 4'd0;
            r_btn_sync <= 4'd0;
        end else begin
            r_btn_meta <= {yellow_button, green_button, blue_button, red_button};
            r_btn_sync <= r_btn_meta;
        end
    end

    // LED source select: echo when idle, one-hot colour in ON, dark in GAP or on clear.
    always_comb begin
        w_led_next = 4'd0;
        unique case (r_state)
            S_IDLE:  w_led_next = r_btn_sync;
            S_ON:    w_led_next = 4'b0001 << w_colour;
            default: w_led_next = 4'd0;
        endcase
        if (w_clear) begin
            w_led_next = 4'd0;
        end
    end

    // Registered LED drives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_led <= 4'd0;
        end else begin
            r_led <= w_led_next;
        end
    end

endmodule

// File: tb/tb_led_sequence_player.sv
// Self-checking bench for led_sequence_player (DEPTH=4, ON_CYCLES=4, GAP_CYCLES=2).
// A table of register accesses covers the address map, hand sequences cover the
// multi-cycle corners, and randomized sequences are checked against a queue model.
module tb_led_sequence_player;

    localparam int DEPTH = 4;
    localparam int ON    = 4;
    localparam int GAP   = 2;
    localparam int PER   = ON + GAP;

    logic        clock;
    logic        reset;
    logic        wren;
    logic [11:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        red_button, blue_button, green_button, yellow_button;
    logic        red_led, blue_led, green_led, yellow_led;
    logic [3:0]  leds;

    assign leds = {yellow_led, green_led, blue_led, red_led};

    led_sequence_player #(
        .DEPTH      (DEPTH),
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP),
        .CNT_W      (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .wren          (wren),
        .addr          (addr),
        .data_in       (data_in),
        .data_out      (data_out),
        .red_button    (red_button),
        .blue_button   (blue_button),
        .green_button  (green_button),
        .yellow_button (yellow_button),
        .red_led       (red_led),
        .blue_led      (blue_led),
        .green_led     (green_led),
        .yellow_led    (yellow_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: the accepted sequence, sticky done and play index.
    logic [1:0] m_seq[$];
    bit         m_done;
    int         m_index;

    typedef struct {
        bit          wr;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wren    = 1'b1;
        addr    = a;
        data_in = d;
        tick();
        wren    = 1'b0;
        addr    = 12'd8;
        data_in = 32'd0;
        #1;
    endtask

    task automatic set_buttons(input logic [3:0] b);
        {yellow_button, green_button, blue_button, red_button} = b;
    endtask

    function automatic logic [31:0] status(input bit busy);
        int n;
        n = m_seq.size();
        return 32'(busy) + ((n == DEPTH) ? 32'd2 : 32'd0) + (m_done ? 32'd4 : 32'd0)
             + 32'(n * 256) + 32'(m_index * 65536);
    endfunction

    task automatic m_append(input logic [1:0] c);
        wr(12'd7, {30'd0, c});
        if (m_seq.size() < DEPTH) m_seq.push_back(c);
    endtask

    task automatic m_clear();
        wr(12'd8, 32'd2);
        m_seq.delete();
        m_done  = 1'b0;
        m_index = 0;
    endtask

    // Start playback and compare LEDs and status on every cycle until idle.
    // With disturb set, a button press, an append and a second start are
    // injected during playback; none of them may change anything.
    task automatic run_playback(input bit disturb, input string tag);
        int n, total, k, c;
        logic [3:0] e;
        n     = m_seq.size();
        total = n * PER;
        wr(12'd8, 32'd1);
        m_done  = 1'b0;
        m_index = 0;
        check({tag, " status at start"}, data_out, status(1'b1));
        for (int j = 1; j <= total + 1; j++) begin
            tick();
            wren = 1'b0; addr = 12'd8; data_in = 32'd0;
            #1;
            if (j <= total) begin
                k = (j - 1) % PER;
                c = (j - 1) / PER;
                e = (k < ON) ? (4'd1 << m_seq[c]) : 4'd0;
            end else begin
                e = 4'd0;
            end
            m_index = (j < total) ? (j / PER) : (n - 1);
            m_done  = (j >= total);
            check($sformatf("%s led cycle %0d", tag, j), 32'(leds), 32'(e));
            check($sformatf("%s status cycle %0d", tag, j), data_out, status(j < total));
            if (disturb) begin
                if (j == 2) set_buttons(4'b0100);
                if (j == 3) begin wren = 1'b1; addr = 12'd7; data_in = 32'd1; end
                if (j == 5) begin wren = 1'b1; addr = 12'd8; data_in = 32'd1; end
                if (j == 7) set_buttons(4'b0000);
            end
        end
    endtask

    initial begin
        reset = 1'b1; wren = 1'b0; addr = 12'd8; data_in = 32'd0;
        set_buttons(4'b0000);
        m_done = 1'b0; m_index = 0;
        #2;
        check("reset status", data_out, 32'd0);
        check("reset leds", 32'(leds), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Register-access table from an empty buffer.
        vecs.push_back('{1'b1, 12'd7, 32'd1, 12'd8, 32'h0000_0100});
        vecs.push_back('{1'b1, 12'd7, 32'd2, 12'd8, 32'h0000_0200});
        vecs.push_back('{1'b1, 12'd7, 32'd3, 12'd8, 32'h0000_0300});
        vecs.push_back('{1'b0, 12'd0, 32'd0, 12'd7, 32'h0000_0000});
        vecs.push_back('{1'b1, 12'd7, 32'hFFFF_FFFC, 12'd8, 32'h0000_0402});
        vecs.push_back('{1'b1, 12'd7, 32'd1, 12'd8, 32'h0000_0402});
        vecs.push_back('{1'b1, 12'd9, 32'd1, 12'd9, 32'h0000_0000});
        vecs.push_back('{1'b0, 12'd0, 32'd0, 12'd8, 32'h0000_0402});
        vecs.push_back('{1'b1, 12'd8, 32'd3, 12'd8, 32'h0000_0000});
        vecs.push_back('{1'b1, 12'd8, 32'd1, 12'd8, 32'h0000_0000});
        vecs.push_back('{1'b0, 12'd0, 32'd0, 12'd8, 32'h0000_0000});
        vecs.push_back('{1'b1, 12'd7, 32'd2, 12'd8, 32'h0000_0100});
        vecs.push_back('{1'b1, 12'd8, 32'd2, 12'd8, 32'h0000_0000});
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                wren = 1'b1; addr = vecs[i].waddr; data_in = vecs[i].wdata;
                tick();
                wren = 1'b0; data_in = 32'd0;
            end else begin
                tick();
            end
            addr = vecs[i].raddr;
            #1;
            check($sformatf("table %0d", i), data_out, vecs[i].exp);
            check($sformatf("table %0d leds", i), 32'(leds), 32'd0);
        end
        addr = 12'd8;

        // Three-colour playback and the resulting status word.
        m_clear();
        m_append(2'd1); m_append(2'd2); m_append(2'd3);
        check("seq3 status before start", data_out, 32'h0000_0300);
        run_playback(1'b0, "seq3");
        check("seq3 final status", data_out, 32'h0002_0304);

        // Inputs during playback are ignored.
        m_clear();
        m_append(2'd0); m_append(2'd0);
        run_playback(1'b1, "disturb");
        check("disturb count kept", data_out, 32'h0001_0204);

        // Clear (start+clear) in the middle of an ON phase.
        m_clear();
        m_append(2'd0); m_append(2'd1);
        wr(12'd8, 32'd1);
        tick();
        check("clear pre leds", 32'(leds), 32'd1);
        wr(12'd8, 32'd3);
        m_seq.delete(); m_done = 1'b0; m_index = 0;
        check("clear status", data_out, 32'd0);
        check("clear leds", 32'(leds), 32'd0);

        // Asynchronous reset mid-GAP and mid-ON.
        m_append(2'd2); m_append(2'd3);
        wr(12'd8, 32'd1);
        for (int j = 0; j < 5; j++) tick();
        check("gap pre status", data_out, 32'h0000_0201);
        #2 reset = 1'b1;
        #1;
        check("reset mid-gap status", data_out, 32'd0);
        check("reset mid-gap leds", 32'(leds), 32'd0);
        tick(); #2 reset = 1'b0;
        tick();
        m_seq.delete(); m_done = 1'b0; m_index = 0;
        m_append(2'd3);
        wr(12'd8, 32'd1);
        tick();
        check("on pre leds", 32'(leds), 32'd8);
        #2 reset = 1'b1;
        #1;
        check("reset mid-on leds", 32'(leds), 32'd0);
        check("reset mid-on status", data_out, 32'd0);
        tick(); #2 reset = 1'b0;
        tick();
        m_seq.delete(); m_done = 1'b0; m_index = 0;

        // Idle button echo with two buttons held.
        set_buttons(4'b1001);
        tick(); tick(); tick();
        check("echo press", 32'(leds), 32'h9);
        set_buttons(4'b0000);
        tick(); tick(); tick();
        check("echo release", 32'(leds), 32'h0);

        // Replay of a finished single-entry sequence.
        m_append(2'd3);
        run_playback(1'b0, "single");
        check("single done", data_out, 32'h0000_0104);
        run_playback(1'b0, "replay");
        check("replay done", data_out, 32'h0000_0104);

        // Randomized sequences against the queue model.
        for (int it = 0; it < 16; it++) begin
            logic [3:0] b;
            int len;
            m_clear();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) m_append(2'($urandom_range(0, 3)));
            check($sformatf("rnd%0d status", it), data_out, status(1'b0));
            b = 4'($urandom_range(0, 15));
            set_buttons(b);
            tick(); tick(); tick();
            check($sformatf("rnd%0d echo", it), 32'(leds), 32'(b));
            set_buttons(4'b0000);
            tick(); tick(); tick();
            run_playback(1'b0, $sformatf("rnd%0d", it));
            if ($urandom_range(0, 1) == 1) begin
                if (m_seq.size() < DEPTH) m_append(2'($urandom_range(0, 3)));
                check($sformatf("rnd%0d extend status", it), data_out, status(1'b0));
                run_playback(1'b0, $sformatf("rnd%0d again", it));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
